// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  localparam logic [2:0] MEM_READ_NONE = 3'b000;
  localparam logic [4:0] REG_X0        = 5'd0;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter that sticks at all-ones.
// The count updates one cycle after INC; a synchronous active-low RESET clears it.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         INC,
  output logic [W-1:0] COUNT
);

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      COUNT <= '0;
    end else if (INC && (COUNT != {W{1'b1}})) begin
      COUNT <= COUNT + 1'b1;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/busy-wait sequencer for the 5-stage RV32 pipeline.
// Controls are Mealy (same-cycle); cache busy freezes everything and overrides hazards.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 1,
  parameter int INIT_CYCLES  = 2,
  parameter int CNT_W        = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             ICACHE_BUSY,
  input  logic             DCACHE_BUSY,
  input  logic [4:0]       ID_RS1,
  input  logic [4:0]       ID_RS2,
  input  logic             ID_RS1_USE,
  input  logic             ID_RS2_USE,
  input  logic [2:0]       EX_MEM_READ,
  input  logic [4:0]       EX_RD,
  input  logic             EX_BRANCH_TAKEN,
  output logic             PC_STALL,
  output logic             IFID_STALL,
  output logic             IFID_FLUSH,
  output logic             IDEX_FLUSH,
  output logic             BUSY_WAIT_OUT,
  output logic [CNT_W-1:0] STALL_COUNT,
  output logic [CNT_W-1:0] FLUSH_COUNT,
  output logic [CNT_W-1:0] WAIT_COUNT
);

  localparam logic [2:0] INIT_LOAD  = 3'(INIT_CYCLES - 1);
  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

  state_t     state;
  logic [2:0] init_cnt;
  logic [2:0] flush_cnt;

  logic mem_busy;
  logic load_use;
  logic stall_inc;
  logic flush_inc;
  logic wait_inc;

  assign mem_busy = ICACHE_BUSY | DCACHE_BUSY;

  // x0 writes are discarded, so a load into x0 can never be a hazard.
  assign load_use = (EX_MEM_READ != MEM_READ_NONE) && (EX_RD != REG_X0) &&
                    ((ID_RS1_USE && (ID_RS1 == EX_RD)) ||
                     (ID_RS2_USE && (ID_RS2 == EX_RD)));

  assign stall_inc = RESET && (state == RUN) && !mem_busy && !EX_BRANCH_TAKEN && load_use;
  assign flush_inc = RESET && (state == RUN) && !mem_busy && EX_BRANCH_TAKEN;
  assign wait_inc  = RESET && (state != INIT) && mem_busy;

  always_comb begin
    PC_STALL      = 1'b0;
    IFID_STALL    = 1'b0;
    IFID_FLUSH    = 1'b0;
    IDEX_FLUSH    = 1'b0;
    BUSY_WAIT_OUT = 1'b0;
    if (!RESET || (state == INIT)) begin
      PC_STALL   = 1'b1;
      IFID_STALL = 1'b1;
      IFID_FLUSH = 1'b1;
      IDEX_FLUSH = 1'b1;
    end else if (mem_busy) begin
      BUSY_WAIT_OUT = 1'b1;
    end else if (state == FLUSH) begin
      IFID_FLUSH = 1'b1;
      IDEX_FLUSH = 1'b1;
    end else if (state == RUN) begin
      if (EX_BRANCH_TAKEN) begin
        IFID_FLUSH = 1'b1;
        IDEX_FLUSH = 1'b1;
      end else if (load_use) begin
        PC_STALL   = 1'b1;
        IFID_STALL = 1'b1;
        IDEX_FLUSH = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state     <= INIT;
      init_cnt  <= INIT_LOAD;
      flush_cnt <= 3'd0;
    end else begin
      case (state)
        INIT: begin
          if (init_cnt == 3'd0) begin
            state <= RUN;
          end else begin
            init_cnt <= init_cnt - 3'd1;
          end
        end
        RUN: begin
          if (!mem_busy && EX_BRANCH_TAKEN && (FLUSH_CYCLES > 1)) begin
            state     <= FLUSH;
            flush_cnt <= FLUSH_LOAD;
          end
        end
        FLUSH: begin
          if (!mem_busy) begin
            if (flush_cnt <= 3'd1) begin
              state <= RUN;
            end else begin
              flush_cnt <= flush_cnt - 3'd1;
            end
          end
        end
        default: state <= INIT;
      endcase
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .CLK   (CLK),
    .RESET (RESET),
    .INC   (stall_inc),
    .COUNT (STALL_COUNT)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .CLK   (CLK),
    .RESET (RESET),
    .INC   (flush_inc),
    .COUNT (FLUSH_COUNT)
  );

  sat_counter #(.W(CNT_W)) u_wait_cnt (
    .CLK   (CLK),
    .RESET (RESET),
    .INC   (wait_inc),
    .COUNT (WAIT_COUNT)
  );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: per-cycle control expectations go through a queue.
module tb_pipeline_hazard_ctrl;

  localparam int CW = 4;

  logic          CLK = 1'b0;
  logic          RESET;
  logic          ICACHE_BUSY;
  logic          DCACHE_BUSY;
  logic [4:0]    ID_RS1;
  logic [4:0]    ID_RS2;
  logic          ID_RS1_USE;
  logic          ID_RS2_USE;
  logic [2:0]    EX_MEM_READ;
  logic [4:0]    EX_RD;
  logic          EX_BRANCH_TAKEN;
  logic          PC_STALL;
  logic          IFID_STALL;
  logic          IFID_FLUSH;
  logic          IDEX_FLUSH;
  logic          BUSY_WAIT_OUT;
  logic [CW-1:0] STALL_COUNT;
  logic [CW-1:0] FLUSH_COUNT;
  logic [CW-1:0] WAIT_COUNT;

  always #5 CLK = ~CLK;

  pipeline_hazard_ctrl #(
    .FLUSH_CYCLES (2),
    .INIT_CYCLES  (2),
    .CNT_W        (CW)
  ) dut (
    .CLK             (CLK),
    .RESET           (RESET),
    .ICACHE_BUSY     (ICACHE_BUSY),
    .DCACHE_BUSY     (DCACHE_BUSY),
    .ID_RS1          (ID_RS1),
    .ID_RS2          (ID_RS2),
    .ID_RS1_USE      (ID_RS1_USE),
    .ID_RS2_USE      (ID_RS2_USE),
    .EX_MEM_READ     (EX_MEM_READ),
    .EX_RD           (EX_RD),
    .EX_BRANCH_TAKEN (EX_BRANCH_TAKEN),
    .PC_STALL        (PC_STALL),
    .IFID_STALL      (IFID_STALL),
    .IFID_FLUSH      (IFID_FLUSH),
    .IDEX_FLUSH      (IDEX_FLUSH),
    .BUSY_WAIT_OUT   (BUSY_WAIT_OUT),
    .STALL_COUNT     (STALL_COUNT),
    .FLUSH_COUNT     (FLUSH_COUNT),
    .WAIT_COUNT      (WAIT_COUNT)
  );

  int errors = 0;
  int checks = 0;

  logic [4:0] exp_q[$];
  string      tag_q[$];

  // Control vector order: {PC_STALL, IFID_STALL, IFID_FLUSH, IDEX_FLUSH, BUSY_WAIT_OUT}
  localparam logic [4:0] C_NONE  = 5'b00000;
  localparam logic [4:0] C_INIT  = 5'b11110;
  localparam logic [4:0] C_STALL = 5'b11010;
  localparam logic [4:0] C_FLUSH = 5'b00110;
  localparam logic [4:0] C_BUSY  = 5'b00001;

  task automatic set_in(input logic ib, input logic db, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic u1, input logic u2,
                        input logic [2:0] mr, input logic [4:0] rd, input logic tk);
    ICACHE_BUSY     = ib;
    DCACHE_BUSY     = db;
    ID_RS1          = rs1;
    ID_RS2          = rs2;
    ID_RS1_USE      = u1;
    ID_RS2_USE      = u2;
    EX_MEM_READ     = mr;
    EX_RD           = rd;
    EX_BRANCH_TAKEN = tk;
  endtask

  task automatic idle();
    set_in(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 3'b000, 5'd0, 1'b0);
  endtask

  // Entered just after a posedge; checks controls at the negedge and returns after the next posedge.
  task automatic step(input string tag, input logic [4:0] exp);
    logic [4:0] obs;
    logic [4:0] e;
    string      t;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    @(negedge CLK);
    obs = {PC_STALL, IFID_STALL, IFID_FLUSH, IDEX_FLUSH, BUSY_WAIT_OUT};
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    checks++;
    assert (obs === e) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", t, obs, e);
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic check_cnt(input string tag, input logic [CW-1:0] s,
                           input logic [CW-1:0] f, input logic [CW-1:0] w);
    checks++;
    assert (STALL_COUNT === s) else begin
      errors++;
      $error("FAIL %s stall_count observed=%0d expected=%0d", tag, STALL_COUNT, s);
    end
    checks++;
    assert (FLUSH_COUNT === f) else begin
      errors++;
      $error("FAIL %s flush_count observed=%0d expected=%0d", tag, FLUSH_COUNT, f);
    end
    checks++;
    assert (WAIT_COUNT === w) else begin
      errors++;
      $error("FAIL %s wait_count observed=%0d expected=%0d", tag, WAIT_COUNT, w);
    end
  endtask

  initial begin
    RESET = 1'b0;
    idle();
    @(posedge CLK);
    #1;

    for (int i = 0; i < 3; i++) step("reset_hold", C_INIT);
    check_cnt("reset_cnt", 4'd0, 4'd0, 4'd0);

    // Busy during INIT must be ignored and not counted.
    RESET = 1'b1;
    set_in(1'b0, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 3'b000, 5'd0, 1'b0);
    step("init_1", C_INIT);
    idle();
    step("init_2", C_INIT);
    step("run_idle", C_NONE);
    check_cnt("after_init", 4'd0, 4'd0, 4'd0);

    set_in(1'b0, 1'b0, 5'd0, 5'd5, 1'b0, 1'b1, 3'b010, 5'd5, 1'b0);
    step("lu_rs2", C_STALL);
    idle();
    step("lu_clear", C_NONE);
    check_cnt("lu_rs2_cnt", 4'd1, 4'd0, 4'd0);

    set_in(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b1, 3'b010, 5'd0, 1'b0);
    step("lu_x0", C_NONE);
    set_in(1'b0, 1'b0, 5'd7, 5'd0, 1'b1, 1'b0, 3'b100, 5'd7, 1'b0);
    step("lu_rs1", C_STALL);
    set_in(1'b0, 1'b0, 5'd7, 5'd0, 1'b0, 1'b0, 3'b010, 5'd7, 1'b0);
    step("lu_no_use", C_NONE);
    set_in(1'b0, 1'b0, 5'd7, 5'd0, 1'b1, 1'b0, 3'b000, 5'd7, 1'b0);
    step("lu_not_load", C_NONE);
    check_cnt("lu_cnt", 4'd2, 4'd0, 4'd0);

    // Taken branch together with a load-use: the redirect wins.
    set_in(1'b0, 1'b0, 5'd0, 5'd5, 1'b0, 1'b1, 3'b010, 5'd5, 1'b1);
    step("br_flush_1", C_FLUSH);
    step("br_flush_2", C_FLUSH);
    idle();
    step("br_done", C_NONE);
    check_cnt("br_cnt", 4'd2, 4'd1, 4'd0);

    set_in(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 3'b000, 5'd0, 1'b1);
    step("br2_flush_1", C_FLUSH);
    set_in(1'b0, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 3'b000, 5'd0, 1'b0);
    for (int i = 0; i < 4; i++) step("busy_in_flush", C_BUSY);
    idle();
    step("br2_flush_2", C_FLUSH);
    step("br2_done", C_NONE);
    check_cnt("busy_cnt", 4'd2, 4'd2, 4'd4);

    set_in(1'b1, 1'b0, 5'd0, 5'd5, 1'b0, 1'b1, 3'b010, 5'd5, 1'b1);
    step("busy_in_run", C_BUSY);
    idle();
    step("busy_run_done", C_NONE);
    check_cnt("busy_run_cnt", 4'd2, 4'd2, 4'd5);

    for (int i = 0; i < 20; i++) begin
      set_in(1'b0, 1'b0, 5'd3, 5'd0, 1'b1, 1'b0, 3'b001, 5'd3, 1'b0);
      step("sat_lu", C_STALL);
      idle();
      step("sat_gap", C_NONE);
    end
    check_cnt("sat_cnt", 4'd15, 4'd2, 4'd5);

    set_in(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 3'b000, 5'd0, 1'b1);
    step("rst_br", C_FLUSH);
    RESET = 1'b0;
    idle();
    step("rst_mid_flush", C_INIT);
    check_cnt("rst_mid_cnt", 4'd0, 4'd0, 4'd0);
    RESET = 1'b1;
    step("reinit_1", C_INIT);
    step("reinit_2", C_INIT);
    step("rerun", C_NONE);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
